// File: rtl/pipe_ctrl_regs_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_regs_pkg
// Shared MIPS control encodings and the packed layouts of the control-side
// pipeline registers.
//   - PC source, write-back address source, EXE operand and ALU encodings
//   - NOP instruction value
//   - one packed struct per pipeline boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB)
//   - regw_addr_sel(): destination register selection done at ID
// -----------------------------------------------------------------------------
package pipe_ctrl_regs_pkg;

    // PC source (ID-stage decode); anything other than PC_NEXT redirects fetch
    localparam logic [2:0] PC_NEXT = 3'd0;
    localparam logic [2:0] PC_JUMP = 3'd1;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_BEQ  = 3'd3;
    localparam logic [2:0] PC_BNE  = 3'd4;

    // Write-back destination select
    localparam logic [1:0] WB_ADDR_RD   = 2'd0;
    localparam logic [1:0] WB_ADDR_RT   = 2'd1;
    localparam logic [1:0] WB_ADDR_LINK = 2'd2;

    // EXE operand A/B select
    localparam logic [1:0] EXE_A_RS   = 2'd0;
    localparam logic [1:0] EXE_A_LINK = 2'd1;
    localparam logic [1:0] EXE_A_SA   = 2'd2;
    localparam logic [1:0] EXE_B_RT   = 2'd0;
    localparam logic [1:0] EXE_B_IMM  = 2'd1;
    localparam logic [1:0] EXE_B_LINK = 2'd2;

    // ALU operation
    localparam logic [3:0] EXE_ALU_ADD = 4'd0;
    localparam logic [3:0] EXE_ALU_SUB = 4'd1;
    localparam logic [3:0] EXE_ALU_AND = 4'd2;
    localparam logic [3:0] EXE_ALU_OR  = 4'd3;
    localparam logic [3:0] EXE_ALU_XOR = 4'd4;
    localparam logic [3:0] EXE_ALU_NOR = 4'd5;
    localparam logic [3:0] EXE_ALU_SL  = 4'd6;
    localparam logic [3:0] EXE_ALU_SR  = 4'd7;
    localparam logic [3:0] EXE_ALU_SRA = 4'd8;
    localparam logic [3:0] EXE_ALU_SLT = 4'd9;
    localparam logic [3:0] EXE_ALU_LUI = 4'd10;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [4:0]  LINK_REG = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
    } ifid_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] a_src;
        logic [1:0] b_src;
        logic [3:0] alu_oper;
        logic       mem_ren;
        logic       mem_wen;
        logic       wb_data_src;
        logic       wb_wen;
        logic       is_load;
        logic       is_branch;
        logic [4:0] regw_addr;
        logic       illegal;
    } idexe_t;

    typedef struct packed {
        logic       valid;
        logic       is_branch;
        logic       is_load;
        logic       mem_ren;
        logic       mem_wen;
        logic       wb_wen;
        logic       wb_data_src;
        logic [4:0] regw_addr;
        logic       illegal;
    } exemem_t;

    typedef struct packed {
        logic       valid;
        logic       wb_wen;
        logic       wb_data_src;
        logic [4:0] regw_addr;
        logic       illegal;
    } memwb_t;

    // Destination register chosen from the IF/ID instruction; code 3 is unused
    // and maps to r0 so it can never clobber a live register.
    function automatic logic [4:0] regw_addr_sel(input logic [1:0]  src,
                                                 input logic [31:0] inst);
        logic [4:0] addr;
        case (src)
            WB_ADDR_RD:   addr = inst[15:11];
            WB_ADDR_RT:   addr = inst[20:16];
            WB_ADDR_LINK: addr = LINK_REG;
            default:      addr = 5'd0;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/pipe_ctrl_regs_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_regs_stage_reg
// One pipeline boundary register of width W.
//   clk  : clock
//   rst  : global synchronous reset (highest priority)
//   clr  : stage reset from the pipeline controller (beats en)
//   en   : stage enable; loads d when set, otherwise holds
//   d/q  : data in / registered data out
// -----------------------------------------------------------------------------
module pipe_ctrl_regs_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_regs
// Control-side pipeline register chain of the MIPS 5-stage CPU. Carries the
// ID-stage decode down ID/EXE -> EXE/MEM -> MEM/WB, tracks per-stage valid
// flags, returns EXE/MEM hazard feedback to the controller and counts retired
// instructions.
//   clk, rst                     : clock, synchronous active-high reset
//   <stage>_rst / <stage>_en     : per-stage clear / load from the controller
//   inst_if                      : fetched instruction
//   pc_src .. unrecognized       : ID-stage decode of inst_id
//   inst_id                      : IF/ID instruction (to decoder/controller)
//   *_valid                      : stage valid flags
//   *_exe / *_mem / *_wb         : stage control fields and hazard feedback
//   illegal_wb                   : unrecognized instruction reached WB
//   retired                      : committed-instruction counter (wraps)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pipe_ctrl_regs
    import pipe_ctrl_regs_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_rst,
    input  logic                if_en,
    input  logic                id_rst,
    input  logic                id_en,
    input  logic                exe_rst,
    input  logic                exe_en,
    input  logic                mem_rst,
    input  logic                mem_en,
    input  logic                wb_rst,
    input  logic                wb_en,
    input  logic [31:0]         inst_if,
    input  logic [2:0]          pc_src,
    input  logic [1:0]          exe_a_src,
    input  logic [1:0]          exe_b_src,
    input  logic [3:0]          exe_alu_oper,
    input  logic                mem_ren,
    input  logic                mem_wen,
    input  logic                wb_data_src,
    input  logic                wb_wen,
    input  logic                is_load,
    input  logic                unrecognized,
    input  logic [1:0]          wb_addr_src,
    output logic [31:0]         inst_id,
    output logic                if_valid,
    output logic                id_valid,
    output logic                exe_valid,
    output logic                mem_valid,
    output logic                wb_valid,
    output logic [1:0]          exe_a_src_exe,
    output logic [1:0]          exe_b_src_exe,
    output logic [3:0]          exe_alu_oper_exe,
    output logic                is_branch_exe,
    output logic                is_load_exe,
    output logic                wb_wen_exe,
    output logic [4:0]          regw_addr_exe,
    output logic                mem_ren_mem,
    output logic                mem_wen_mem,
    output logic                is_branch_mem,
    output logic                is_load_mem,
    output logic                wb_wen_mem,
    output logic [4:0]          regw_addr_mem,
    output logic                wb_wen_wb,
    output logic                wb_data_src_wb,
    output logic [4:0]          regw_addr_wb,
    output logic                illegal_wb,
    output logic [RETIRE_W-1:0] retired
);

    logic    pc_valid_q;
    ifid_t   ifid_d,   ifid_q;
    idexe_t  idexe_d,  idexe_q;
    exemem_t exemem_d, exemem_q;
    memwb_t  memwb_d,  memwb_q;

    // ---------------------------------------------------------------- PC valid
    // Fetch is always producing an instruction unless the IF stage is cleared.
    pipe_ctrl_regs_stage_reg #(.W(1)) u_pc_valid (
        .clk (clk), .rst (rst), .clr (if_rst), .en (if_en),
        .d   (1'b1), .q (pc_valid_q)
    );

    // ------------------------------------------------------------------ IF/ID
    always_comb begin
        ifid_d       = '0;
        ifid_d.valid = pc_valid_q;
        ifid_d.inst  = inst_if;
    end

    pipe_ctrl_regs_stage_reg #(.W($bits(ifid_t))) u_ifid (
        .clk (clk), .rst (rst), .clr (id_rst), .en (id_en),
        .d   (ifid_d), .q (ifid_q)
    );

    // ----------------------------------------------------------------- ID/EXE
    // An unrecognized instruction still occupies a valid slot so it can be
    // reported at WB, but every side effect (register/memory writes, loads,
    // redirects) is stripped here so it cannot disturb architectural state.
    always_comb begin
        idexe_d             = '0;
        idexe_d.valid       = ifid_q.valid;
        idexe_d.a_src       = exe_a_src;
        idexe_d.b_src       = exe_b_src;
        idexe_d.alu_oper    = exe_alu_oper;
        idexe_d.mem_ren     = mem_ren;
        idexe_d.mem_wen     = mem_wen;
        idexe_d.wb_data_src = wb_data_src;
        idexe_d.wb_wen      = wb_wen;
        idexe_d.is_load     = is_load;
        idexe_d.is_branch   = (pc_src != PC_NEXT);
        idexe_d.regw_addr   = regw_addr_sel(wb_addr_src, ifid_q.inst);
        idexe_d.illegal     = unrecognized;
        if (unrecognized) begin
            idexe_d.mem_ren   = 1'b0;
            idexe_d.mem_wen   = 1'b0;
            idexe_d.wb_wen    = 1'b0;
            idexe_d.is_load   = 1'b0;
            idexe_d.is_branch = 1'b0;
        end
    end

    pipe_ctrl_regs_stage_reg #(.W($bits(idexe_t))) u_idexe (
        .clk (clk), .rst (rst), .clr (exe_rst), .en (exe_en),
        .d   (idexe_d), .q (idexe_q)
    );

    // ---------------------------------------------------------------- EXE/MEM
    always_comb begin
        exemem_d             = '0;
        exemem_d.valid       = idexe_q.valid;
        exemem_d.is_branch   = idexe_q.is_branch;
        exemem_d.is_load     = idexe_q.is_load;
        exemem_d.mem_ren     = idexe_q.mem_ren;
        exemem_d.mem_wen     = idexe_q.mem_wen;
        exemem_d.wb_wen      = idexe_q.wb_wen;
        exemem_d.wb_data_src = idexe_q.wb_data_src;
        exemem_d.regw_addr   = idexe_q.regw_addr;
        exemem_d.illegal     = idexe_q.illegal;
    end

    pipe_ctrl_regs_stage_reg #(.W($bits(exemem_t))) u_exemem (
        .clk (clk), .rst (rst), .clr (mem_rst), .en (mem_en),
        .d   (exemem_d), .q (exemem_q)
    );

    // ----------------------------------------------------------------- MEM/WB
    always_comb begin
        memwb_d             = '0;
        memwb_d.valid       = exemem_q.valid;
        memwb_d.wb_wen      = exemem_q.wb_wen;
        memwb_d.wb_data_src = exemem_q.wb_data_src;
        memwb_d.regw_addr   = exemem_q.regw_addr;
        memwb_d.illegal     = exemem_q.illegal;
    end

    pipe_ctrl_regs_stage_reg #(.W($bits(memwb_t))) u_memwb (
        .clk (clk), .rst (rst), .clr (wb_rst), .en (wb_en),
        .d   (memwb_d), .q (memwb_q)
    );

    // ---------------------------------------------------------- retire count
    // An instruction commits on the edge that moves it out of WB; a held or
    // cleared WB stage, or an illegal instruction, does not count.
    logic [RETIRE_W-1:0] retired_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
        end else if (memwb_q.valid && wb_en && !wb_rst && !memwb_q.illegal) begin
            retired_reg <= retired_reg + RETIRE_W'(1);
        end
    end

    // ----------------------------------------------------------------- outputs
    assign if_valid         = pc_valid_q;
    assign id_valid         = ifid_q.valid;
    assign inst_id          = ifid_q.inst;

    assign exe_valid        = idexe_q.valid;
    assign exe_a_src_exe    = idexe_q.a_src;
    assign exe_b_src_exe    = idexe_q.b_src;
    assign exe_alu_oper_exe = idexe_q.alu_oper;
    assign is_branch_exe    = idexe_q.is_branch;
    assign is_load_exe      = idexe_q.is_load;
    assign wb_wen_exe       = idexe_q.wb_wen;
    assign regw_addr_exe    = idexe_q.regw_addr;

    assign mem_valid        = exemem_q.valid;
    assign mem_ren_mem      = exemem_q.mem_ren;
    assign mem_wen_mem      = exemem_q.mem_wen;
    assign is_branch_mem    = exemem_q.is_branch;
    assign is_load_mem      = exemem_q.is_load;
    assign wb_wen_mem       = exemem_q.wb_wen;
    assign regw_addr_mem    = exemem_q.regw_addr;

    assign wb_valid         = memwb_q.valid;
    assign wb_wen_wb        = memwb_q.wb_wen;
    assign wb_data_src_wb   = memwb_q.wb_data_src;
    assign regw_addr_wb     = memwb_q.regw_addr;
    assign illegal_wb       = memwb_q.illegal;

    assign retired          = retired_reg;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_regs
// Directed scenarios for pipe_ctrl_regs (RETIRE_W=4 so the counter wrap is
// reachable). Each task drives one scenario and compares outputs against
// hand-computed values one cycle at a time.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_regs;
    import pipe_ctrl_regs_pkg::*;

    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst;
    logic if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
    logic [31:0] inst_if;
    logic [2:0]  pc_src;
    logic [1:0]  exe_a_src, exe_b_src, wb_addr_src;
    logic [3:0]  exe_alu_oper;
    logic        mem_ren, mem_wen, wb_data_src, wb_wen, is_load, unrecognized;

    logic [31:0] inst_id;
    logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic [1:0]  exe_a_src_exe, exe_b_src_exe;
    logic [3:0]  exe_alu_oper_exe;
    logic        is_branch_exe, is_load_exe, wb_wen_exe;
    logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
    logic        mem_ren_mem, mem_wen_mem, is_branch_mem, is_load_mem, wb_wen_mem;
    logic        wb_wen_wb, wb_data_src_wb, illegal_wb;
    logic [RW-1:0] retired;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] ADDI_R5 = {6'h08, 5'd1, 5'd5, 16'h0010};
    localparam logic [31:0] JAL_I   = {6'h03, 26'h0000100};
    localparam logic [31:0] LW_R8   = {6'h23, 5'd2, 5'd8, 16'h0004};
    localparam logic [31:0] BAD_I   = 32'hFC00_0000;

    always #5 clk = ~clk;

    pipe_ctrl_regs #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst),
        .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
        .wb_rst(wb_rst), .wb_en(wb_en),
        .inst_if(inst_if), .pc_src(pc_src), .exe_a_src(exe_a_src), .exe_b_src(exe_b_src),
        .exe_alu_oper(exe_alu_oper), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .wb_data_src(wb_data_src), .wb_wen(wb_wen), .is_load(is_load),
        .unrecognized(unrecognized), .wb_addr_src(wb_addr_src),
        .inst_id(inst_id), .if_valid(if_valid), .id_valid(id_valid),
        .exe_valid(exe_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .exe_a_src_exe(exe_a_src_exe), .exe_b_src_exe(exe_b_src_exe),
        .exe_alu_oper_exe(exe_alu_oper_exe), .is_branch_exe(is_branch_exe),
        .is_load_exe(is_load_exe), .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe),
        .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem), .is_branch_mem(is_branch_mem),
        .is_load_mem(is_load_mem), .wb_wen_mem(wb_wen_mem), .regw_addr_mem(regw_addr_mem),
        .wb_wen_wb(wb_wen_wb), .wb_data_src_wb(wb_data_src_wb), .regw_addr_wb(regw_addr_wb),
        .illegal_wb(illegal_wb), .retired(retired)
    );

    // OR of every output bit, used for "everything cleared" comparisons
    wire any_out = |{inst_id, if_valid, id_valid, exe_valid, mem_valid, wb_valid,
                     exe_a_src_exe, exe_b_src_exe, exe_alu_oper_exe, is_branch_exe,
                     is_load_exe, wb_wen_exe, regw_addr_exe, mem_ren_mem, mem_wen_mem,
                     is_branch_mem, is_load_mem, wb_wen_mem, regw_addr_mem, wb_wen_wb,
                     wb_data_src_wb, regw_addr_wb, illegal_wb, retired};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_dec();
        pc_src = PC_NEXT; exe_a_src = 2'd0; exe_b_src = 2'd0; exe_alu_oper = 4'd0;
        mem_ren = 1'b0; mem_wen = 1'b0; wb_data_src = 1'b0; wb_wen = 1'b0;
        is_load = 1'b0; unrecognized = 1'b0; wb_addr_src = WB_ADDR_RD;
    endtask

    // Everything enabled, fetch held empty so only injected instructions flow.
    task automatic idle();
        rst = 1'b0;
        if_rst = 1'b1; id_rst = 1'b0; exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
        if_en = 1'b1; id_en = 1'b1; exe_en = 1'b1; mem_en = 1'b1; wb_en = 1'b1;
        inst_if = NOP_INST;
        clr_dec();
    endtask

    // Places one valid instruction in IF/ID (two edges), leaving IF empty.
    task automatic load_id(input logic [31:0] inst);
        if_rst = 1'b0;
        tick();
        if_rst = 1'b1;
        inst_if = inst;
        tick();
        inst_if = NOP_INST;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en} = 10'($urandom);
        inst_if = $urandom; pc_src = 3'($urandom); exe_a_src = 2'($urandom);
        exe_b_src = 2'($urandom); exe_alu_oper = 4'($urandom); wb_addr_src = 2'($urandom);
        {mem_ren, mem_wen, wb_data_src, wb_wen, is_load, unrecognized} = 6'($urandom);
        tick(); tick();
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL reset_outputs any_out=%b exp=0", any_out); end
        checks++; if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if (inst_id !== 32'h0) begin failures++; $display("FAIL reset_inst_id got=%h exp=0", inst_id); end
        idle();
        if_rst = 1'b0;
        tick();
        checks++; if (if_valid !== 1'b1 || id_valid !== 1'b0) begin failures++; $display("FAIL release_if_valid if=%b id=%b exp if=1 id=0", if_valid, id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL release_id_valid got=%b exp=1", id_valid); end
        idle();
        repeat (6) tick();
        $display("test_reset done retired=%0d", retired);
    endtask

    task automatic test_addi();
        logic [RW-1:0] base;
        load_id(ADDI_R5);
        checks++; if (id_valid !== 1'b1 || inst_id !== ADDI_R5) begin failures++; $display("FAIL addi_inst_id got=%h v=%b exp=%h v=1", inst_id, id_valid, ADDI_R5); end
        base = retired;
        wb_addr_src = WB_ADDR_RT; wb_wen = 1'b1; exe_b_src = EXE_B_IMM; exe_alu_oper = EXE_ALU_ADD;
        tick();
        clr_dec();
        checks++; if (exe_valid !== 1'b1 || regw_addr_exe !== 5'd5 || wb_wen_exe !== 1'b1 || exe_b_src_exe !== EXE_B_IMM) begin
            failures++; $display("FAIL addi_exe v=%b regw=%0d wen=%b bsrc=%0d exp v=1 regw=5 wen=1 bsrc=1", exe_valid, regw_addr_exe, wb_wen_exe, exe_b_src_exe); end
        tick();
        checks++; if (mem_valid !== 1'b1 || regw_addr_mem !== 5'd5 || wb_wen_mem !== 1'b1) begin
            failures++; $display("FAIL addi_mem v=%b regw=%0d wen=%b exp v=1 regw=5 wen=1", mem_valid, regw_addr_mem, wb_wen_mem); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_wen_wb !== 1'b1 || regw_addr_wb !== 5'd5 || retired !== base) begin
            failures++; $display("FAIL addi_wb v=%b wen=%b regw=%0d ret=%0d exp v=1 wen=1 regw=5 ret=%0d", wb_valid, wb_wen_wb, regw_addr_wb, retired, base); end
        tick();
        checks++; if (retired !== RW'(base + 1)) begin failures++; $display("FAIL addi_retired got=%0d exp=%0d", retired, RW'(base + 1)); end
        $display("test_addi done retired=%0d", retired);
    endtask

    task automatic test_jal_stall();
        logic [RW-1:0] base;
        load_id(JAL_I);
        base = retired;
        pc_src = PC_JUMP; wb_addr_src = WB_ADDR_LINK; wb_wen = 1'b1; exe_a_src = EXE_A_LINK;
        id_rst = 1'b1; if_rst = 1'b0; inst_if = 32'h1234_5678;
        tick();
        clr_dec();
        checks++; if (is_branch_exe !== 1'b1 || regw_addr_exe !== 5'd31 || exe_a_src_exe !== EXE_A_LINK) begin
            failures++; $display("FAIL jal_exe br=%b regw=%0d asrc=%0d exp br=1 regw=31 asrc=1", is_branch_exe, regw_addr_exe, exe_a_src_exe); end
        tick();
        checks++; if (id_valid !== 1'b0 || inst_id !== 32'h0 || is_branch_mem !== 1'b1 || regw_addr_mem !== 5'd31) begin
            failures++; $display("FAIL jal_stall1 idv=%b inst=%h brm=%b regm=%0d exp idv=0 inst=0 brm=1 regm=31", id_valid, inst_id, is_branch_mem, regw_addr_mem); end
        tick();
        checks++; if (id_valid !== 1'b0 || inst_id !== 32'h0 || regw_addr_wb !== 5'd31 || wb_valid !== 1'b1) begin
            failures++; $display("FAIL jal_stall2 idv=%b inst=%h regwb=%0d wbv=%b exp idv=0 inst=0 regwb=31 wbv=1", id_valid, inst_id, regw_addr_wb, wb_valid); end
        if_rst = 1'b1; inst_if = NOP_INST;
        tick();
        checks++; if (id_valid !== 1'b0 || retired !== RW'(base + 1)) begin
            failures++; $display("FAIL jal_stall3 idv=%b ret=%0d exp idv=0 ret=%0d", id_valid, retired, RW'(base + 1)); end
        id_rst = 1'b0;
        repeat (5) tick();
        checks++; if (retired !== RW'(base + 1)) begin failures++; $display("FAIL jal_one_retire got=%0d exp=%0d", retired, RW'(base + 1)); end
        $display("test_jal_stall done retired=%0d", retired);
    endtask

    task automatic test_lw_freeze();
        logic [RW-1:0] base;
        load_id(LW_R8);
        wb_addr_src = WB_ADDR_RT; wb_wen = 1'b1; is_load = 1'b1; mem_ren = 1'b1;
        wb_data_src = 1'b1; exe_b_src = EXE_B_IMM;
        tick();
        base = retired;
        checks++; if (is_load_exe !== 1'b1 || regw_addr_exe !== 5'd8) begin
            failures++; $display("FAIL lw_exe ld=%b regw=%0d exp ld=1 regw=8", is_load_exe, regw_addr_exe); end
        if_rst = 1'b0;
        {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            pc_src = 3'($urandom); wb_addr_src = 2'($urandom); is_load = 1'($urandom);
            inst_if = $urandom;
            tick();
            checks++; if (is_load_exe !== 1'b1 || regw_addr_exe !== 5'd8 || exe_valid !== 1'b1 || retired !== base || if_valid !== 1'b0) begin
                failures++; $display("FAIL freeze_hold cyc=%0d ld=%b regw=%0d v=%b ret=%0d ifv=%b exp ld=1 regw=8 v=1 ret=%0d ifv=0",
                                     i, is_load_exe, regw_addr_exe, exe_valid, retired, if_valid, base); end
        end
        idle();
        tick();
        checks++; if (is_load_mem !== 1'b1 || regw_addr_mem !== 5'd8 || mem_ren_mem !== 1'b1) begin
            failures++; $display("FAIL lw_resume_mem ld=%b regw=%0d ren=%b exp ld=1 regw=8 ren=1", is_load_mem, regw_addr_mem, mem_ren_mem); end
        tick();
        checks++; if (regw_addr_wb !== 5'd8 || wb_data_src_wb !== 1'b1 || wb_valid !== 1'b1) begin
            failures++; $display("FAIL lw_resume_wb regw=%0d dsrc=%b v=%b exp regw=8 dsrc=1 v=1", regw_addr_wb, wb_data_src_wb, wb_valid); end
        tick();
        checks++; if (retired !== RW'(base + 1)) begin failures++; $display("FAIL lw_retired got=%0d exp=%0d", retired, RW'(base + 1)); end
        $display("test_lw_freeze done retired=%0d", retired);
    endtask

    task automatic test_unrecognized();
        logic [RW-1:0] base;
        load_id(BAD_I);
        base = retired;
        unrecognized = 1'b1; wb_wen = 1'b1; mem_wen = 1'b1; mem_ren = 1'b1;
        is_load = 1'b1; pc_src = PC_BEQ;
        tick();
        clr_dec();
        checks++; if (exe_valid !== 1'b1 || wb_wen_exe !== 1'b0 || is_branch_exe !== 1'b0 || is_load_exe !== 1'b0) begin
            failures++; $display("FAIL illegal_exe v=%b wen=%b br=%b ld=%b exp v=1 wen=0 br=0 ld=0", exe_valid, wb_wen_exe, is_branch_exe, is_load_exe); end
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_wen_mem !== 1'b0 || mem_ren_mem !== 1'b0) begin
            failures++; $display("FAIL illegal_mem v=%b wen=%b ren=%b exp v=1 wen=0 ren=0", mem_valid, mem_wen_mem, mem_ren_mem); end
        tick();
        checks++; if (illegal_wb !== 1'b1 || wb_valid !== 1'b1 || wb_wen_wb !== 1'b0) begin
            failures++; $display("FAIL illegal_wb ill=%b v=%b wen=%b exp ill=1 v=1 wen=0", illegal_wb, wb_valid, wb_wen_wb); end
        tick();
        checks++; if (retired !== base || illegal_wb !== 1'b0) begin
            failures++; $display("FAIL illegal_no_retire ret=%0d ill=%b exp ret=%0d ill=0", retired, illegal_wb, base); end
        $display("test_unrecognized done retired=%0d", retired);
    endtask

    task automatic test_exe_rst();
        logic [RW-1:0] base;
        load_id(ADDI_R5);
        base = retired;
        wb_addr_src = WB_ADDR_RT; wb_wen = 1'b1; exe_alu_oper = EXE_ALU_OR;
        exe_rst = 1'b1; exe_en = 1'b1;
        tick();
        clr_dec(); exe_rst = 1'b0;
        checks++; if (exe_valid !== 1'b0 || regw_addr_exe !== 5'd0 || wb_wen_exe !== 1'b0 || exe_alu_oper_exe !== 4'd0) begin
            failures++; $display("FAIL exe_rst_clear v=%b regw=%0d wen=%b alu=%0d exp all 0", exe_valid, regw_addr_exe, wb_wen_exe, exe_alu_oper_exe); end
        repeat (4) tick();
        checks++; if (retired !== base) begin failures++; $display("FAIL exe_rst_no_retire got=%0d exp=%0d", retired, base); end
        $display("test_exe_rst done retired=%0d", retired);
    endtask

    task automatic test_wrap_and_midreset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_rst = 1'b0; inst_if = ADDI_R5;
        wb_addr_src = WB_ADDR_RT; wb_wen = 1'b1; exe_b_src = EXE_B_IMM;
        for (int e = 1; e <= 24; e++) begin
            if_rst = (e >= 18);
            tick();
            if (e == 20) begin checks++; if (retired !== 4'd15) begin failures++; $display("FAIL wrap_pre got=%0d exp=15", retired); end end
            if (e == 21) begin checks++; if (retired !== 4'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", retired); end end
            if (e == 24) begin checks++; if (retired !== 4'd1) begin failures++; $display("FAIL wrap_one got=%0d exp=1", retired); end end
        end
        $display("test_wrap done retired=%0d", retired);
        if_rst = 1'b0;
        repeat (3) tick();
        checks++; if (exe_valid !== 1'b1 || retired !== 4'd1) begin
            failures++; $display("FAIL midrst_pre exev=%b ret=%0d exp exev=1 ret=1", exe_valid, retired); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL midrst_clear any_out=%b exp=0", any_out); end
        $display("test_midreset done retired=%0d", retired);
    endtask

    initial begin
        idle();
        test_reset();
        test_addi();
        test_jal_stall();
        test_lw_freeze();
        test_unrecognized();
        test_exe_rst();
        test_wrap_and_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_ctrl_regs.md
# pipe_ctrl_regs

Control-side pipeline register chain for the MIPS 5-stage pipelined CPU. It receives the decode outputs and per-stage rst/en signals produced by the pipeline controller, carries the control fields down IF/ID → ID/EXE → EXE/MEM → MEM/WB, and returns the per-stage valid flags and the EXE/MEM hazard feedback (is_branch, is_load, regw_addr, wb_wen) the controller consumes. It also maintains a retired-instruction counter.

## Interface
- RETIRE_W, 32, width of the retired-instruction counter
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high; clears every register
- if_rst/if_en, id_rst/id_en, exe_rst/exe_en, mem_rst/mem_en, wb_rst/wb_en  in  1 each  stage reset/enable from controller
- inst_if  in  32  fetched instruction
- pc_src  in  3  ID-stage decode; branch/jump when nonzero (PC_NEXT=0)
- exe_a_src, exe_b_src  in  2 each;  exe_alu_oper  in  4;  mem_ren, mem_wen, wb_data_src, wb_wen, is_load, unrecognized  in  1 each  ID-stage decode
- wb_addr_src  in  2  RD=0, RT=1, LINK=2
- inst_id  out  32  IF/ID instruction, to controller
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage valid flags
- exe_a_src_exe, exe_b_src_exe  out  2;  exe_alu_oper_exe  out  4  EXE controls
- is_branch_exe, is_load_exe, wb_wen_exe  out  1;  regw_addr_exe  out  5  EXE feedback
- mem_ren_mem, mem_wen_mem, is_branch_mem, is_load_mem, wb_wen_mem  out  1;  regw_addr_mem  out  5  MEM controls/feedback
- wb_wen_wb, wb_data_src_wb  out  1;  regw_addr_wb  out  5  WB controls
- illegal_wb  out  1  unrecognized instruction at WB
- retired  out  RETIRE_W  count of committed instructions

## Operation
- Update rule per register group X (PC valid, IF/ID, ID/EXE, EXE/MEM, MEM/WB, driven by if_/id_/exe_/mem_/wb_ rst/en): if rst or X_rst, clear; else if X_en, load upstream; else hold. Stage rst beats en.
- if_valid loads 1. id_valid loads if_valid. exe_valid loads id_valid, and so on downstream.
- Cleared state (bubble): valid=0, inst_id=0, every control field 0, regw_addr=0.
- regw_addr computed at ID: RD → inst_id[15:11], RT → inst_id[20:16], LINK → 31, code 3 → 0.
- is_branch = (pc_src != 0), captured at ID/EXE.
- Unrecognized at ID: enters EXE with valid=1, all write/read enables and is_branch cleared, and an illegal bit set. The illegal bit travels down the pipeline as illegal_wb.
- Field flow:
  - EXE/MEM copies is_branch, is_load, mem_ren, mem_wen, wb_wen, wb_data_src, regw_addr, illegal.
  - MEM/WB copies wb_wen, wb_data_src, regw_addr, illegal.
- Retire counter: on a clock edge with wb_valid=1, wb_en=1, wb_rst=0, illegal_wb=0 and rst=0, increments by 1 modulo 2^RETIRE_W. It clears on rst only.
- Stage registers are independent; no implicit bubble insertion when an upstream stage is held.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Reset value of every output is 0. This includes retired and inst_id.
- Latency: an ID-stage decode with exe_en=1 appears on *_exe outputs after 1 cycle, *_mem after 2, *_wb after 3.
- inst_if with id_en=1 appears on inst_id after 1 cycle.
- Freeze (all en=0, debug suspend): every output holds, including retired.
- Branch stall (id_rst=1, others en): IF/ID becomes a bubble next cycle, and downstream keeps advancing.
- rst mid-operation clears everything on the next edge regardless of en.

## Structure
- Shared package/header: PC_NEXT, WB_ADDR_RD/RT/LINK, EXE_A_*/EXE_B_*/EXE_ALU_* encodings, NOP instruction value (32'h0). These are reused from the existing MIPS define header, not redefined here.
- One natural sub-module: stage_reg (parameterized width; rst/clr/en/d/q with the priority rule above), instantiated once per pipeline boundary.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs → all outputs 0. Release with all en=1 → if_valid=1 next cycle, id_valid=1 one cycle later.
- ADDI r5 (wb_addr_src=RT, inst[20:16]=5, wb_wen=1) at ID → regw_addr_exe=5/wb_wen_exe=1 at +1, regw_addr_mem=5 at +2, wb_wen_wb=1 at +3, retired increments by 1 after +3.
- JAL at ID (pc_src=PC_JUMP, wb_addr_src=LINK) with id_rst=1 the following 3 cycles → is_branch_exe=1, regw_addr_exe=31. id_valid=0 and inst_id=0 during the stall. Only one instruction is retired.
- LW r8 followed by freeze (all en=0) for 4 cycles → is_load_exe=1 and regw_addr_exe=8 held unchanged, retired constant. Release resumes exactly.
- Unrecognized instruction → exe_valid=1, wb_wen_exe=0, mem_wen_mem=0. illegal_wb=1 at +3 with retired unchanged.
- RETIRE_W=4 with 17 valid ADDIs retired → retired wraps to 1. exe_rst=1 and exe_en=1 together → ID/EXE cleared.
